// File: rtl/regfile_ctx_pkg.sv
// Shared types and constants for the register-file context switch sequencer.
package regfile_ctx_pkg;

  localparam int NUM_REGS   = 32;
  localparam int ADDR_W     = 5;
  localparam int DATA_W     = 32;
  localparam int WORD_BYTES = 4;

  localparam logic [ADDR_W-1:0] FIRST_REG = ADDR_W'(1);
  localparam logic [ADDR_W-1:0] LAST_REG  = ADDR_W'(NUM_REGS - 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SAVE_RD,
    ST_SAVE_WR,
    ST_RESTORE_RD,
    ST_RESTORE_WR,
    ST_DONE
  } state_t;

  typedef enum logic [1:0] {
    MODE_SAVE_RESTORE = 2'b00,
    MODE_SAVE_ONLY    = 2'b01,
    MODE_RESTORE_ONLY = 2'b10,
    MODE_ALIAS_SR     = 2'b11
  } mode_t;

  // Byte address of register slot idx; wraps modulo 2^32.
  function automatic logic [DATA_W-1:0] slot_addr(input logic [DATA_W-1:0] base,
                                                  input logic [ADDR_W-1:0] idx);
    return base + DATA_W'(idx) * DATA_W'(WORD_BYTES);
  endfunction

endpackage

// File: rtl/regfile_port_mux.sv
// Selects which side drives the register-file ports: the core or the sequencer.
module regfile_port_mux
  import regfile_ctx_pkg::*;
(
  input  logic              owner,
  input  logic              core_write,
  input  logic [ADDR_W-1:0] core_inaddress,
  input  logic [DATA_W-1:0] core_in,
  input  logic [ADDR_W-1:0] core_out1address,
  input  logic              ctl_write,
  input  logic [ADDR_W-1:0] ctl_inaddress,
  input  logic [DATA_W-1:0] ctl_in,
  input  logic [ADDR_W-1:0] ctl_out1address,
  output logic              rf_write,
  output logic [ADDR_W-1:0] rf_inaddress,
  output logic [DATA_W-1:0] rf_in,
  output logic [ADDR_W-1:0] rf_out1address
);

  assign rf_write       = owner ? ctl_write       : core_write;
  assign rf_inaddress   = owner ? ctl_inaddress   : core_inaddress;
  assign rf_in          = owner ? ctl_in          : core_in;
  assign rf_out1address = owner ? ctl_out1address : core_out1address;

endmodule

// File: rtl/regfile_ctx_switcher.sv
// Streams x1..x31 to a save area and/or reloads them from a restore area,
// stalling the core and owning the register-file ports while active.
module regfile_ctx_switcher
  import regfile_ctx_pkg::*;
(
  input  logic              CLK,
  input  logic              RESET,
  input  logic              CTX_SWITCH,
  input  logic [1:0]        MODE,
  input  logic [DATA_W-1:0] SAVE_BASE,
  input  logic [DATA_W-1:0] RESTORE_BASE,
  output logic              BUSY,
  output logic              DONE,
  input  logic              CORE_WRITE,
  input  logic [ADDR_W-1:0] CORE_INADDRESS,
  input  logic [DATA_W-1:0] CORE_IN,
  input  logic [ADDR_W-1:0] CORE_OUT1ADDRESS,
  output logic              RF_WRITE,
  output logic [ADDR_W-1:0] RF_INADDRESS,
  output logic [DATA_W-1:0] RF_IN,
  output logic [ADDR_W-1:0] RF_OUT1ADDRESS,
  input  logic [DATA_W-1:0] RF_OUT1,
  output logic              MEM_READ,
  output logic              MEM_WRITE,
  output logic [DATA_W-1:0] MEM_ADDRESS,
  output logic [DATA_W-1:0] MEM_WRITEDATA,
  input  logic [DATA_W-1:0] MEM_READDATA,
  input  logic              MEM_BUSYWAIT
);

  state_t            state_reg, state_next;
  logic [ADDR_W-1:0] idx_reg, idx_next;
  logic              chain_restore_reg, chain_restore_next;
  logic [DATA_W-1:0] save_base_reg, save_base_next;
  logic [DATA_W-1:0] restore_base_reg, restore_base_next;
  logic [DATA_W-1:0] data_reg, data_next;

  logic              ctl_write;
  logic [ADDR_W-1:0] ctl_inaddress;
  logic [DATA_W-1:0] ctl_in;
  logic [ADDR_W-1:0] ctl_out1address;

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_reg         <= ST_IDLE;
      idx_reg           <= '0;
      chain_restore_reg <= 1'b0;
      save_base_reg     <= '0;
      restore_base_reg  <= '0;
      data_reg          <= '0;
    end else begin
      state_reg         <= state_next;
      idx_reg           <= idx_next;
      chain_restore_reg <= chain_restore_next;
      save_base_reg     <= save_base_next;
      restore_base_reg  <= restore_base_next;
      data_reg          <= data_next;
    end
  end

  always_comb begin
    state_next         = state_reg;
    idx_next           = idx_reg;
    chain_restore_next = chain_restore_reg;
    save_base_next     = save_base_reg;
    restore_base_next  = restore_base_reg;
    data_next          = data_reg;
    ctl_write          = 1'b0;
    ctl_inaddress      = idx_reg;
    ctl_in             = data_reg;
    ctl_out1address    = idx_reg;
    MEM_READ           = 1'b0;
    MEM_WRITE          = 1'b0;
    MEM_ADDRESS        = '0;
    MEM_WRITEDATA      = '0;

    case (state_reg)
      ST_IDLE: begin
        if (CTX_SWITCH) begin
          save_base_next     = SAVE_BASE;
          restore_base_next  = RESTORE_BASE;
          chain_restore_next = (MODE != MODE_SAVE_ONLY);
          idx_next           = FIRST_REG;
          state_next         = (MODE == MODE_RESTORE_ONLY) ? ST_RESTORE_RD : ST_SAVE_RD;
        end
      end

      // reg_file read is address-change triggered: give it one cycle to settle
      ST_SAVE_RD: state_next = ST_SAVE_WR;

      ST_SAVE_WR: begin
        MEM_WRITE     = 1'b1;
        MEM_ADDRESS   = slot_addr(save_base_reg, idx_reg);
        MEM_WRITEDATA = RF_OUT1;
        if (!MEM_BUSYWAIT) begin
          if (idx_reg == LAST_REG) begin
            if (chain_restore_reg) begin
              idx_next   = FIRST_REG;
              state_next = ST_RESTORE_RD;
            end else begin
              state_next = ST_DONE;
            end
          end else begin
            idx_next   = idx_reg + ADDR_W'(1);
            state_next = ST_SAVE_RD;
          end
        end
      end

      ST_RESTORE_RD: begin
        MEM_READ    = 1'b1;
        MEM_ADDRESS = slot_addr(restore_base_reg, idx_reg);
        if (!MEM_BUSYWAIT) begin
          data_next  = MEM_READDATA;
          state_next = ST_RESTORE_WR;
        end
      end

      ST_RESTORE_WR: begin
        ctl_write = 1'b1;
        if (idx_reg == LAST_REG) begin
          state_next = ST_DONE;
        end else begin
          idx_next   = idx_reg + ADDR_W'(1);
          state_next = ST_RESTORE_RD;
        end
      end

      ST_DONE: state_next = ST_IDLE;

      default: state_next = ST_IDLE;
    endcase
  end

  assign BUSY = (state_reg != ST_IDLE) && (state_reg != ST_DONE);
  assign DONE = (state_reg == ST_DONE);

  regfile_port_mux u_port_mux (
    .owner            (BUSY),
    .core_write       (CORE_WRITE),
    .core_inaddress   (CORE_INADDRESS),
    .core_in          (CORE_IN),
    .core_out1address (CORE_OUT1ADDRESS),
    .ctl_write        (ctl_write),
    .ctl_inaddress    (ctl_inaddress),
    .ctl_in           (ctl_in),
    .ctl_out1address  (ctl_out1address),
    .rf_write         (RF_WRITE),
    .rf_inaddress     (RF_INADDRESS),
    .rf_in            (RF_IN),
    .rf_out1address   (RF_OUT1ADDRESS)
  );

endmodule
